// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch buffer.
//   INST_W     instruction / address width
//   ZERO_WORD  all-zero word
//   NOP_INST   instruction shown to decode when no entry is valid (addi x0,x0,0)
//   fetch_state_e  RUN / DRAIN fetch states
//   align_word()   force a byte address onto a word boundary
package if_fetch_buffer_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;
    localparam logic [INST_W-1:0] NOP_INST  = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] addr);
        return {addr[INST_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_buffer_fifo.sv
// fetch_fifo: small synchronous FIFO, DEPTH x WIDTH, head visible on dout.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr          synchronous clear of pointers and count
//   push, din    write din at the tail (ignored when full and not popping)
//   pop          advance the head (ignored when empty)
//   dout         current head entry
//   full, empty  occupancy flags
//   count        number of stored entries
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: fetch stage between the PC register and decode.
// Issues curr_pc to instruction memory, tags each request with its PC,
// queues {pc, inst} for decode and drops responses that belong to a
// stream killed by a redirect.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   curr_pc                  address to fetch this cycle
//   fetch_stall              1 = fetch not accepted, PC register holds
//   flush                    redirect: kill queue and in-flight fetches
//   imem_req/addr/gnt        request channel to instruction memory
//   imem_rvalid/rdata        in-order response channel
//   id_valid/ready/pc/inst   head of the fetch queue to decode
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | fetching; responses are written into the queue
// ST_DRAIN | waiting out drop_cnt stale responses; no new requests
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] curr_pc,
    output logic              fetch_stall,
    input  logic              flush,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst
);
    localparam int SUM_W = CNT_W + 1;

    fetch_state_e      state;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  tag_count;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  out_next;
    logic [SUM_W-1:0]  in_use;
    logic              tag_full, tag_empty, q_full, q_empty;
    logic [INST_W-1:0] tag_pc, q_pc, q_inst;
    logic              issue, q_push, q_pop;

    // A queue slot is reserved at issue time: queued plus in-flight never exceeds DEPTH.
    assign in_use      = {1'b0, q_count} + {1'b0, tag_count};
    assign imem_req    = !rst && !flush && (state == ST_RUN) && (in_use < SUM_W'(DEPTH));
    assign imem_addr   = align_word(curr_pc);
    assign issue       = imem_req && imem_gnt;
    assign fetch_stall = !issue;

    assign q_push   = imem_rvalid && (state == ST_RUN) && !flush;
    assign q_pop    = !q_empty && id_ready && !flush;
    assign out_next = tag_count + CNT_W'(issue) - CNT_W'(imem_rvalid);

    // The tag FIFO is never flushed: every response, kept or dropped, pops its tag,
    // so tag_count is the true number of requests still owed by memory.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(INST_W), .CNT_W(CNT_W)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (issue),
        .pop   (imem_rvalid),
        .din   (curr_pc),
        .dout  (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*INST_W), .CNT_W(CNT_W)) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (q_push),
        .pop   (q_pop),
        .din   ({tag_pc, imem_rdata}),
        .dout  ({q_pc, q_inst}),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign id_valid = !q_empty;
    assign id_pc    = q_empty ? ZERO_WORD : q_pc;
    assign id_inst  = q_empty ? NOP_INST  : q_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            drop_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (flush && (out_next != '0)) begin
                        state    <= ST_DRAIN;
                        drop_cnt <= out_next;
                    end
                end
                ST_DRAIN: begin
                    // A further flush here changes nothing: no new request can be in flight.
                    if (imem_rvalid) begin
                        drop_cnt <= drop_cnt - CNT_W'(1);
                        if (drop_cnt == CNT_W'(1)) state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (rst) q_count <= CNT_W'(DEPTH));
    a_q_room:    assert property (@(posedge clk) disable iff (rst) !(q_push && q_full && !q_pop));
    a_tag_room:  assert property (@(posedge clk) disable iff (rst) !(issue && tag_full));
    a_tag_avail: assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && tag_empty));

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;
    import if_fetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] curr_pc;
    logic        fetch_stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    always #5 clk = ~clk;

    if_fetch_buffer #(.DEPTH(2), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .curr_pc     (curr_pc),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { logic [31:0] addr; int cyc; } req_t;

    exp_t        exp_q[$];   // granted, not yet popped, in the live stream
    req_t        pend[$];    // memory model: requests owed a response
    logic [31:0] popped[$];
    int          n_chk, n_fail, cyc, resp_cnt, drain_left, n_issue;
    logic        gnt_set, rv_set, rdy_set, fl_set, hold_chk;
    logic [31:0] redirect, next_pc, held_addr;
    int          snap;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: entered at a negedge, drives inputs, checks, books, returns at the next negedge.
    task automatic step();
        logic req_exp, do_pop, do_issue;
        exp_t e;
        curr_pc  = next_pc;
        imem_gnt = gnt_set;
        id_ready = rdy_set;
        flush    = fl_set;
        if (rv_set && pend.size() > 0 && pend[0].cyc < cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        req_exp = !fl_set && drain_left == 0 && exp_q.size() < 2;
        chk("imem_req", imem_req, req_exp);
        chk("fetch_stall", fetch_stall, !(req_exp && gnt_set));
        chk("id_valid", id_valid, resp_cnt > 0);
        if (resp_cnt == 0) chk("id_inst_idle", id_inst, NOP_INST);
        if (req_exp) chk("imem_addr", imem_addr, {curr_pc[31:2], 2'b00});
        if (hold_chk) begin
            chk("t6_stall", fetch_stall, 1);
            chk("t6_addr_hold", imem_addr, held_addr);
        end
        do_pop   = resp_cnt > 0 && rdy_set && !fl_set;
        do_issue = req_exp && gnt_set;
        if (do_pop) begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc, e.pc);
            chk("id_inst", id_inst, e.inst);
            popped.push_back(e.pc);
            resp_cnt--;
        end
        if (imem_rvalid) begin
            void'(pend.pop_front());
            if (drain_left > 0) drain_left--;
            else if (!fl_set) resp_cnt++;
        end
        if (do_issue) begin
            pend.push_back('{addr: {curr_pc[31:2], 2'b00}, cyc: cyc});
            exp_q.push_back('{pc: curr_pc, inst: mem_word({curr_pc[31:2], 2'b00})});
            n_issue++;
            next_pc = curr_pc + 32'd4;
        end
        if (fl_set) begin
            exp_q.delete();
            resp_cnt   = 0;
            drain_left = pend.size();
            next_pc    = redirect;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic restart(input logic [31:0] r);
        fl_set = 1'b1; gnt_set = 1'b0; rv_set = 1'b1; rdy_set = 1'b0; redirect = r;
        step();
        fl_set = 1'b0;
        for (int i = 0; i < 8 && drain_left > 0; i++) step();
        popped.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; resp_cnt = 0; drain_left = 0; n_issue = 0;
        rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
        curr_pc = '0; imem_rdata = '0; next_pc = '0; redirect = '0; held_addr = '0;
        gnt_set = 1'b0; rv_set = 1'b0; rdy_set = 1'b0; fl_set = 1'b0; hold_chk = 1'b0;

        // 1 reset
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_fetch_stall", fetch_stall, 1);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_inst", id_inst, 32'h13);
        chk("rst_id_pc", id_pc, 0);
        rst = 1'b0;

        // 2 streaming
        next_pc = 32'h0; gnt_set = 1'b1; rv_set = 1'b1; rdy_set = 1'b1;
        repeat (12) step();
        chk("t2_pops", popped.size() >= 3, 1);
        chk("t2_pc0", popped[0], 32'h0);
        chk("t2_pc1", popped[1], 32'h4);
        chk("t2_pc2", popped[2], 32'h8);

        // 3 backpressure
        restart(32'h0);
        gnt_set = 1'b1; rv_set = 1'b1; rdy_set = 1'b0;
        repeat (5) step();
        #1;
        chk("t3_req_held", imem_req, 0);
        chk("t3_stall", fetch_stall, 1);
        chk("t3_head", id_pc, 32'h0);
        snap = n_issue;
        rdy_set = 1'b1; step();
        rdy_set = 1'b0;
        repeat (4) step();
        chk("t3_one_fetch", n_issue - snap, 1);
        chk("t3_popped", popped[0], 32'h0);

        // 4 flush with two requests in flight
        restart(32'h0);
        gnt_set = 1'b1; rv_set = 1'b0; rdy_set = 1'b1;
        repeat (3) step();
        #1;
        chk("t4_pc", imem_addr, 32'h8);
        fl_set = 1'b1; redirect = 32'h100;
        step();
        fl_set = 1'b0; rv_set = 1'b1;
        repeat (10) step();
        chk("t4_first", popped[0], 32'h100);

        // 5 flush and response in the same cycle, one entry queued
        restart(32'h0);
        rdy_set = 1'b0; gnt_set = 1'b1; rv_set = 1'b0;
        step();
        rv_set = 1'b1;
        step();
        fl_set = 1'b1; gnt_set = 1'b0; redirect = 32'h200;
        step();
        fl_set = 1'b0;
        #1;
        chk("t5_empty", id_valid, 0);
        rdy_set = 1'b1; gnt_set = 1'b1;
        repeat (6) step();
        chk("t5_first", popped[0], 32'h200);

        // 6 memory grant stall
        restart(32'h40);
        gnt_set = 1'b1; rv_set = 1'b1; rdy_set = 1'b1;
        repeat (3) step();
        gnt_set = 1'b0; held_addr = {next_pc[31:2], 2'b00}; hold_chk = 1'b1;
        repeat (3) step();
        hold_chk = 1'b0;

        // random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            gnt_set  = ($urandom_range(0, 3) != 0);
            rv_set   = ($urandom_range(0, 2) != 0);
            rdy_set  = ($urandom_range(0, 3) != 0);
            fl_set   = ($urandom_range(0, 63) == 0);
            redirect = 32'($urandom_range(0, 1023)) << 2;
            step();
        end
        fl_set = 1'b0; gnt_set = 1'b0; rv_set = 1'b1; rdy_set = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() > 0 || pend.size() > 0); i++) step();
        chk("final_exp_left", exp_q.size(), 0);
        #1;
        chk("final_idle", id_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
